writeback_stage_reg: RTL and testbench
======================================

// Module: writeback_stage_reg
// PURPOSE
//   Registered MEM/WB stage: captures memory-stage results into a pipeline register
//   with stall/flush control, then formats sub-word load data and selects the
//   register-file write data/destination for the decode-stage register file.
//   Generalises the combinational writeback path with link-address writeback,
//   byte/halfword loads and a qualified write enable.
// PARAMETERS
//   NBITS     32  datapath width; multiple of 8, >= 32
//   NREG_BITS 5   register index width
//   LINK_REG  31  destination index used when i_flg_ALU_dst = 2'b11
// PORTS
//   i_clk            in   1          clock, rising edge
//   i_rst_n          in   1          asynchronous reset, active low
//   i_stall          in   1          hold pipeline register contents
//   i_flush          in   1          invalidate the incoming slot
//   i_valid          in   1          MEM-stage slot holds a real instruction
//   i_reg_wr         in   1          instruction writes the register file
//   i_wb_src         in   2          00 mem data, 01 ALU result, 10/11 link PC
//   i_flg_ALU_dst    in   2          00 rt, 01 rd, 10 zero, 11 LINK_REG
//   i_ld_size        in   2          00 byte, 01 half, 10/11 word
//   i_ld_unsigned    in   1          1 zero-extend, 0 sign-extend
//   i_ALU_rslt       in   NBITS      ALU result; [1:0] is the load byte offset
//   i_data           in   NBITS      raw memory read data
//   i_link_pc        in   NBITS      return address (PC+8)
//   i_rd, i_rt       in   NREG_BITS  candidate destinations
//   o_valid          out  1          registered slot valid
//   o_wr_en          out  1          register-file write strobe
//   o_wr_data        out  NBITS      register-file write data
//   o_reg_sel        out  NREG_BITS  register-file write index
// BEHAVIOUR
//   - Reset (async, i_rst_n=0): all pipeline fields cleared. o_valid=0, o_wr_en=0,
//     o_wr_data=0, o_reg_sel=0. Release is synchronous to the next i_clk edge.
//   - Capture on rising i_clk. Priority: i_flush > i_stall > load.
//     flush: valid<=0, other fields unchanged. stall: all fields held.
//     load: all inputs registered.
//   - Latency: 1 cycle. Outputs are combinational functions of registered fields only.
//     There is no input-to-output combinational path.
//   - Destination: 00 rt_q, 01 rd_q, 10 0, 11 LINK_REG.
//   - o_wr_en = valid_q & reg_wr_q & (o_reg_sel != 0). A write to r0 never strobes.
//   - Data by wb_src_q: 00 formatted load, 01 alu_q, 1x link_pc_q.
//   - Load formatting, ofs = alu_q[1:0], little-endian lanes within data_q[31:0]:
//     byte: lane ofs, data_q[8*ofs+7 -: 8], extended to NBITS.
//     half: lane ofs[1], data_q[16*ofs[1]+15 -: 16]. ofs[0] is ignored; misaligned
//       halves are not trapped here.
//     word: NBITS=32 gives data_q unchanged. NBITS>32 gives data_q[31:0] extended
//       per ld_unsigned_q.
//     Extension: unsigned fills with 0; signed replicates the lane MSB.
//   - o_valid=0 forces o_wr_en=0. o_wr_data/o_reg_sel still reflect the held fields
//     (don't-care to the consumer).
//   - Flush while stalled: the slot is invalidated; the held fields remain.
// CONFIGURATION
//   WB_RETIRE_CNT_EN defined:
//     - Adds port o_retire_cnt (out, 32) and a 32-bit counter.
//     - The counter is cleared by reset and increments on each cycle with o_wr_en=1.
//     - It wraps 0xFFFFFFFF -> 0 silently and is unaffected by stall/flush except
//       through o_wr_en.
//   WB_RETIRE_CNT_EN undefined: neither the port nor the counter exists; behaviour
//     is otherwise identical.
// TESTING
//   1. Reset mid-stream, i_rst_n low async between edges:
//      outputs go 0 immediately, o_wr_en=0 until the next valid load.
//   2. i_valid=1, i_reg_wr=1, wb_src=01, ALU=0x0000_1234, dst=01, rd=7:
//      next cycle o_wr_en=1, o_reg_sel=7, o_wr_data=0x0000_1234.
//   3. Signed byte load, data=0x80FF_7F01, ofs=3:
//      o_wr_data=0xFFFF_FF80. Same with unsigned: 0x0000_0080. Half, ofs=2, signed:
//      0xFFFF_80FF.
//   4. JAL-style: wb_src=10, dst=11, link_pc=0x0000_0048:
//      o_reg_sel=31, o_wr_data=0x48. dst=10 with reg_wr=1: o_wr_en=0.
//   5. Stall 3 cycles with inputs changing:
//      outputs hold. Flush and stall together: o_valid=0 on the next cycle.
//   6. WB_RETIRE_CNT_EN:
//      5 writes plus 2 r0 writes plus 1 flushed slot gives o_retire_cnt=5.
//      Preload near 0xFFFFFFFF: the count wraps to 0.

Source files
------------

// File: rtl/writeback_stage_reg.sv
// MEM/WB pipeline register with sub-word load formatting and register-file write select.
// Optional retire counter (port o_retire_cnt) when WB_RETIRE_CNT_EN is defined.
module writeback_stage_reg #(
    parameter int NBITS     = 32,
    parameter int NREG_BITS = 5,
    parameter int LINK_REG  = 31
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic                 i_reg_wr,
    input  logic [1:0]           i_wb_src,
    input  logic [1:0]           i_flg_ALU_dst,
    input  logic [1:0]           i_ld_size,
    input  logic                 i_ld_unsigned,
    input  logic [NBITS-1:0]     i_ALU_rslt,
    input  logic [NBITS-1:0]     i_data,
    input  logic [NBITS-1:0]     i_link_pc,
    input  logic [NREG_BITS-1:0] i_rd,
    input  logic [NREG_BITS-1:0] i_rt,
    output logic                 o_valid,
    output logic                 o_wr_en,
    output logic [NBITS-1:0]     o_wr_data,
    output logic [NREG_BITS-1:0] o_reg_sel
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]          o_retire_cnt
`endif
);

    localparam logic [NREG_BITS-1:0] LINK_IDX = NREG_BITS'(LINK_REG);

    logic                 r_valid;
    logic                 r_reg_wr;
    logic [1:0]           r_wb_src;
    logic [1:0]           r_dst;
    logic [1:0]           r_ld_size;
    logic                 r_ld_unsigned;
    logic [NBITS-1:0]     r_alu;
    logic [NBITS-1:0]     r_data;
    logic [NBITS-1:0]     r_link_pc;
    logic [NREG_BITS-1:0] r_rd;
    logic [NREG_BITS-1:0] r_rt;

    // Flush only drops the valid bit; the payload keeps whatever it held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid       <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_wb_src      <= '0;
            r_dst         <= '0;
            r_ld_size     <= '0;
            r_ld_unsigned <= 1'b0;
            r_alu         <= '0;
            r_data        <= '0;
            r_link_pc     <= '0;
            r_rd          <= '0;
            r_rt          <= '0;
        end else if (i_flush) begin
            r_valid       <= 1'b0;
        end else if (!i_stall) begin
            r_valid       <= i_valid;
            r_reg_wr      <= i_reg_wr;
            r_wb_src      <= i_wb_src;
            r_dst         <= i_flg_ALU_dst;
            r_ld_size     <= i_ld_size;
            r_ld_unsigned <= i_ld_unsigned;
            r_alu         <= i_ALU_rslt;
            r_data        <= i_data;
            r_link_pc     <= i_link_pc;
            r_rd          <= i_rd;
            r_rt          <= i_rt;
        end
    end

    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [NBITS-1:0] w_word;
    logic [NBITS-1:0] w_ld_fmt;

    always_comb begin
        w_byte = r_data[7:0];
        case (r_alu[1:0])
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            default: w_byte = r_data[31:24];
        endcase
        w_half = r_alu[1] ? r_data[31:16] : r_data[15:0];
    end

    generate
        if (NBITS == 32) begin : g_word32
            assign w_word = r_data;
        end else begin : g_wordext
            assign w_word = {{(NBITS-32){~r_ld_unsigned & r_data[31]}}, r_data[31:0]};
        end
    endgenerate

    always_comb begin
        w_ld_fmt = w_word;
        case (r_ld_size)
            2'b00:   w_ld_fmt = {{(NBITS-8){~r_ld_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_ld_fmt = {{(NBITS-16){~r_ld_unsigned & w_half[15]}}, w_half};
            default: w_ld_fmt = w_word;
        endcase
    end

    always_comb begin
        o_reg_sel = r_rt;
        case (r_dst)
            2'b00:   o_reg_sel = r_rt;
            2'b01:   o_reg_sel = r_rd;
            2'b10:   o_reg_sel = '0;
            default: o_reg_sel = LINK_IDX;
        endcase
        o_wr_data = r_link_pc;
        case (r_wb_src)
            2'b00:   o_wr_data = w_ld_fmt;
            2'b01:   o_wr_data = r_alu;
            default: o_wr_data = r_link_pc;
        endcase
    end

    assign o_valid = r_valid;
    // r0 is hardwired zero, so a write aimed at it never strobes.
    assign o_wr_en = r_valid & r_reg_wr & (o_reg_sel != '0);

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_retire_cnt <= '0;
        else if (o_wr_en)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign o_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_writeback_stage_reg.sv
// Scoreboard bench for writeback_stage_reg: expected outputs queued per driven slot,
// popped and compared one cycle later.
module tb_writeback_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, valid = 1'b0, reg_wr = 1'b0;
    logic [1:0]  wb_src = '0, dst = '0, ld_size = '0;
    logic        ld_uns = 1'b0;
    logic [31:0] alu = '0, data = '0, link = '0;
    logic [4:0]  rd = '0, rt = '0;
    logic        o_valid, o_wr_en;
    logic [31:0] o_wr_data;
    logic [4:0]  o_reg_sel;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] o_retire_cnt;
`endif

    writeback_stage_reg #(.NBITS(32), .NREG_BITS(5), .LINK_REG(31)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_valid(valid), .i_reg_wr(reg_wr), .i_wb_src(wb_src), .i_flg_ALU_dst(dst),
        .i_ld_size(ld_size), .i_ld_unsigned(ld_uns), .i_ALU_rslt(alu), .i_data(data),
        .i_link_pc(link), .i_rd(rd), .i_rt(rt),
        .o_valid(o_valid), .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_reg_sel(o_reg_sel)
`ifdef WB_RETIRE_CNT_EN
        , .o_retire_cnt(o_retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        v;
        logic        we;
        logic [31:0] d;
        logic [4:0]  s;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic setin(input logic v, input logic w, input logic [1:0] src,
                         input logic [1:0] ds, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] dt, input logic [31:0] lk,
                         input logic [4:0] r_d, input logic [4:0] r_t);
        valid = v; reg_wr = w; wb_src = src; dst = ds; ld_size = sz; ld_uns = u;
        alu = a; data = dt; link = lk; rd = r_d; rt = r_t;
    endtask

    // Queue the expectation for the currently driven slot, clock once, then compare.
    task automatic step(input string tag, input logic v, input logic we,
                        input logic [31:0] d, input logic [4:0] s);
        exp_t e;
        e.tag = tag; e.v = v; e.we = we; e.d = d; e.s = s;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({e.tag, ".valid"}, 32'(o_valid), 32'(e.v));
        chk({e.tag, ".wr_en"}, 32'(o_wr_en), 32'(e.we));
        chk({e.tag, ".data"},  o_wr_data, e.d);
        chk({e.tag, ".sel"},   32'(o_reg_sel), 32'(e.s));
    endtask

    initial begin
        logic [31:0] ra;
        logic [4:0]  rr;

        @(posedge clk); #1;
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.wr_en", 32'(o_wr_en), 0);
        chk("rst.data",  o_wr_data, 0);
        chk("rst.sel",   32'(o_reg_sel), 0);
        rst_n = 1'b1;

`ifdef WB_RETIRE_CNT_EN
        for (int i = 0; i < 5; i++) begin
            setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'(i + 1), 0, 0, 5'd3, 0);
            step("cnt.w", 1, 1, 32'(i + 1), 5'd3);
        end
        setin(1, 1, 2'b01, 2'b10, 2'b10, 0, 32'h9, 0, 0, 5'd3, 0);
        step("cnt.r0a", 1, 0, 32'h9, 0);
        setin(1, 1, 2'b01, 2'b00, 2'b10, 0, 32'hA, 0, 0, 5'd3, 0);
        step("cnt.r0b", 1, 0, 32'hA, 0);
        flush = 1'b1;
        setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'hB, 0, 0, 5'd4, 0);
        step("cnt.fl", 0, 0, 32'hA, 0);
        flush = 1'b0;
        setin(0, 1, 2'b01, 2'b01, 2'b10, 0, 32'hC, 0, 0, 5'd4, 0);
        step("cnt.idle", 0, 0, 32'hC, 5'd4);
        chk("cnt.total", o_retire_cnt, 32'd5);
`endif

        // ALU writeback to rd
        setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'h0000_1234, 0, 0, 5'd7, 5'd2);
        step("alu", 1, 1, 32'h0000_1234, 5'd7);

        // load formatting on 0x80FF_7F01
        setin(1, 1, 2'b00, 2'b00, 2'b00, 0, 32'h3, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lb.o3", 1, 1, 32'hFFFF_FF80, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b00, 1, 32'h3, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lbu.o3", 1, 1, 32'h0000_0080, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b00, 0, 32'h0, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lb.o0", 1, 1, 32'h0000_0001, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b00, 0, 32'h1, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lb.o1", 1, 1, 32'h0000_007F, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b00, 0, 32'h2, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lb.o2", 1, 1, 32'hFFFF_FFFF, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b01, 0, 32'h2, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lh.o2", 1, 1, 32'hFFFF_80FF, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b01, 0, 32'h3, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lh.o3", 1, 1, 32'hFFFF_80FF, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b01, 1, 32'h2, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lhu.o2", 1, 1, 32'h0000_80FF, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b01, 0, 32'h0, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lh.o0", 1, 1, 32'h0000_7F01, 5'd5);
        setin(1, 1, 2'b00, 2'b00, 2'b10, 0, 32'h1, 32'h80FF_7F01, 0, 5'd1, 5'd5);
        step("lw", 1, 1, 32'h80FF_7F01, 5'd5);

        // link writeback and destination corner cases
        setin(1, 1, 2'b10, 2'b11, 2'b10, 0, 32'h55, 32'h66, 32'h0000_0048, 5'd1, 5'd5);
        step("jal", 1, 1, 32'h0000_0048, 5'd31);
        setin(1, 1, 2'b11, 2'b11, 2'b10, 0, 32'h55, 32'h66, 32'h0000_0100, 5'd1, 5'd5);
        step("link11", 1, 1, 32'h0000_0100, 5'd31);
        setin(1, 1, 2'b10, 2'b10, 2'b10, 0, 32'h55, 32'h66, 32'h0000_0048, 5'd1, 5'd5);
        step("dst.zero", 1, 0, 32'h0000_0048, 5'd0);
        setin(1, 1, 2'b01, 2'b00, 2'b10, 0, 32'h77, 0, 0, 5'd1, 5'd0);
        step("rt.r0", 1, 0, 32'h77, 5'd0);
        setin(1, 0, 2'b01, 2'b01, 2'b10, 0, 32'h78, 0, 0, 5'd6, 5'd0);
        step("no.regwr", 1, 0, 32'h78, 5'd6);
        setin(0, 1, 2'b01, 2'b01, 2'b10, 0, 32'h79, 0, 0, 5'd6, 5'd0);
        step("invalid", 0, 0, 32'h79, 5'd6);

        // stall holds, flush drops valid only
        setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'hAAAA, 0, 0, 5'd9, 5'd0);
        step("pre.stall", 1, 1, 32'hAAAA, 5'd9);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'($urandom), 0, 0, 5'(i + 10), 0);
            step("stall", 1, 1, 32'hAAAA, 5'd9);
        end
        flush = 1'b1;
        step("stall.flush", 0, 0, 32'hAAAA, 5'd9);
        stall = 1'b0; flush = 1'b0;
        setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'hBBBB, 0, 0, 5'd12, 0);
        step("post.stall", 1, 1, 32'hBBBB, 5'd12);
        flush = 1'b1;
        setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'hCCCC, 0, 0, 5'd13, 0);
        step("flush", 0, 0, 32'hBBBB, 5'd12);
        flush = 1'b0;

        // random ALU passthrough
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rr = 5'($urandom_range(1, 31));
            setin(1, 1, 2'b01, 2'b01, 2'b10, 0, ra, 32'($urandom), 0, rr, 0);
            step("rand", 1, 1, ra, rr);
        end

        // asynchronous reset between edges
        setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'hDEAD, 0, 0, 5'd8, 0);
        step("pre.rst", 1, 1, 32'hDEAD, 5'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(o_valid), 0);
        chk("arst.wr_en", 32'(o_wr_en), 0);
        chk("arst.data",  o_wr_data, 0);
        chk("arst.sel",   32'(o_reg_sel), 0);
        @(negedge clk);
        rst_n = 1'b1;
        setin(0, 1, 2'b01, 2'b01, 2'b10, 0, 32'h1111, 0, 0, 5'd8, 0);
        step("post.rst", 0, 0, 32'h1111, 5'd8);
        setin(1, 1, 2'b01, 2'b01, 2'b10, 0, 32'h2222, 0, 0, 5'd8, 0);
        step("post.rst.ld", 1, 1, 32'h2222, 5'd8);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
